// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the requester-side and RAM-side signals of the memory arbiter.
//   The arbiter connects through the 'slave' modport; whatever drives it
//   (fetch/memory stages plus the RAM model) uses the 'master' modport.
//
//   Requester side : iREN, iaddr -> ihit, iload
//                    dREN, dWEN, daddr, dstore -> dhit, dload
//   RAM side       : ramREN, ramWEN, ramaddr, ramstore -> ramload, ram_ready
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        ihit;
    logic [31:0] iload;

    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dhit;
    logic [31:0] dload;

    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ram_ready;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
        output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
        input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single RAM port between the instruction-fetch requester and
//   the data requester. Every access walks IDLE -> IACC/DACC -> DONE: the
//   winning request is latched in IDLE, the RAM strobe is held until
//   ram_ready, and the owner gets a one-cycle hit in DONE with registered
//   load data. Data requests win over fetches.
//
//   Ports:
//     CLK  - clock, rising edge
//     RST  - synchronous active-high reset
//     bus  - mem_arbiter_if.slave (requester handshakes and RAM port)
//
//   Parameter:
//     DSTREAK - data grants allowed while a fetch waits before the fetch is
//               forced through (only used with the starvation guard)
//
//   Build option:
//     ARB_STARVE_GUARD_EN - when defined, builds the 3-bit 'streak' counter
//                           that periodically lets a pending fetch through.
//                           Undefined gives strict data priority.
module mem_arbiter #(
    parameter int DSTREAK = 4
) (
    input logic         CLK,
    input logic         RST,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, IACC, DACC, DONE} state_t;

    state_t      state, nextState;
    logic [31:0] latAddr;
    logic [31:0] latStore;
    logic        latWrite;
    logic        latData;
    logic        dropped;
    logic [31:0] iloadReg;
    logic [31:0] dloadReg;
    logic        dataReq;
    logic        forceFetch;

    assign dataReq = bus.dREN || bus.dWEN;

`ifdef ARB_STARVE_GUARD_EN
    logic [2:0] streak;

    assign forceFetch = bus.iREN && (streak == 3'(DSTREAK));

    // Counts data grants that overtook a waiting fetch; any IDLE decision
    // with no fetch waiting, or any fetch grant, starts the count over.
    always_ff @(posedge CLK) begin
        if (RST) begin
            streak <= 3'd0;
        end else if (state == IDLE) begin
            if (nextState == DACC && bus.iREN)
                streak <= streak + 3'd1;
            else
                streak <= 3'd0;
        end
    end
`else
    assign forceFetch = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (forceFetch)
                    nextState = IACC;
                else if (dataReq)
                    nextState = DACC;
                else if (bus.iREN)
                    nextState = IACC;
            end
            IACC, DACC: begin
                if (bus.ram_ready)
                    nextState = DONE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Strobes and hits decode from registered state only, so request inputs
    // never reach the RAM combinationally.
    always_comb begin
        bus.ramREN = 1'b0;
        bus.ramWEN = 1'b0;
        bus.ihit   = 1'b0;
        bus.dhit   = 1'b0;
        case (state)
            IACC: bus.ramREN = 1'b1;
            DACC: begin
                bus.ramREN = !latWrite;
                bus.ramWEN = latWrite;
            end
            DONE: begin
                bus.ihit = !latData && !dropped;
                bus.dhit = latData && !dropped;
            end
            default: ;
        endcase
    end

    // Access latches and load registers. 'dropped' remembers that the owner
    // let go of its request at some point during the access, which cancels
    // the hit but not the RAM transfer or the load update.
    always_ff @(posedge CLK) begin
        if (RST) begin
            latAddr  <= 32'd0;
            latStore <= 32'd0;
            latWrite <= 1'b0;
            latData  <= 1'b0;
            dropped  <= 1'b0;
            iloadReg <= 32'd0;
            dloadReg <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    dropped <= 1'b0;
                    if (nextState == DACC) begin
                        latAddr  <= bus.daddr;
                        latStore <= bus.dstore;
                        latWrite <= bus.dWEN;
                        latData  <= 1'b1;
                    end else if (nextState == IACC) begin
                        latAddr  <= bus.iaddr;
                        latData  <= 1'b0;
                    end
                end
                IACC: begin
                    if (!bus.iREN)
                        dropped <= 1'b1;
                    if (bus.ram_ready)
                        iloadReg <= bus.ramload;
                end
                DACC: begin
                    if (!dataReq)
                        dropped <= 1'b1;
                    if (bus.ram_ready && !latWrite)
                        dloadReg <= bus.ramload;
                end
                default: ;
            endcase
        end
    end

    assign bus.ramaddr  = latAddr;
    assign bus.ramstore = latStore;
    assign bus.iload    = iloadReg;
    assign bus.dload    = dloadReg;

endmodule
